// File: rtl/dds_pkg.sv
// dds_pkg: shared DDS constants and elaboration-time sine table generation
// Exports N_DEFAULT (default width), SINE_PEAK (2^(N-1)-1), sine_peak(), sine_mag() and sine_entry().
package dds_pkg;
  localparam int N_DEFAULT = 8;
  localparam longint PI_Q30 = 64'sd3373259426;
  function automatic int sine_peak(int n);
    return (1 << (n - 1)) - 1;
  endfunction
  localparam int SINE_PEAK = sine_peak(N_DEFAULT);
  // Integer-only Taylor series in Q30 so the table builds without real math; k is a quarter-wave index 0..2^(n-1).
  function automatic int sine_mag(int k, int n);
    longint x, t, s;
    x = (PI_Q30 * longint'(k)) >>> n;
    t = x;
    s = x;
    for (int i = 1; i < 12; i++) begin
      t = -(((t * x) >>> 30) * x >>> 30) / longint'(4 * i * i + 2 * i);
      s += t;
    end
    return int'((longint'(sine_peak(n)) * s + (64'sd1 <<< 29)) >>> 30);
  endfunction
  // Full-circle entry built by mirroring the quarter wave, so odd and half-wave symmetry are exact.
  function automatic int sine_entry(int k, int n);
    int q, i, m;
    q = 1 << (n - 1);
    i = k & (q - 1);
    m = sine_mag(((k >> (n - 1)) & 1) != 0 ? q - i : i, n);
    return ((k >> n) & 1) != 0 ? -m : m;
  endfunction
endpackage

// File: rtl/dds_if.sv
// dds_if: DDS control/sample bundle
// freq_in/phase_in/amplitude_in: N+1-bit unsigned controls; out: 2N+1-bit signed sample.
interface dds_if #(parameter int N = dds_pkg::N_DEFAULT);
  logic [N:0] freq_in;
  logic [N:0] phase_in;
  logic [N:0] amplitude_in;
  logic signed [2*N:0] out;
  modport master(output freq_in, phase_in, amplitude_in, input out);
  modport slave(input freq_in, phase_in, amplitude_in, output out);
endinterface

// File: rtl/dds_sine_lut.sv
// dds_sine_lut: combinational phase-to-sine lookup p -> S(p)
// p: N+1-bit phase; s: signed N-bit sine. Macro DDS_QUARTER_LUT_EN selects the quarter-wave table.
module dds_sine_lut import dds_pkg::*; #(parameter int N = N_DEFAULT) (
  input  logic [N:0]          p,
  output logic signed [N-1:0] s
);
`ifdef DDS_QUARTER_LUT_EN
  localparam int Q = 2 ** (N - 1);
  logic [N-2:0] mag_tab [Q+1];
  logic [N-1:0] idx;
  logic [N-2:0] mag;
  for (genvar k = 0; k <= Q; k++) begin : g_tab
    assign mag_tab[k] = (N-1)'(sine_mag(k, N));
  end
  // p[N-1] mirrors the index within the half wave, p[N] negates for the lower half.
  always_comb begin
    idx = p[N-1] ? N'(Q) - N'(p[N-2:0]) : N'(p[N-2:0]);
    mag = mag_tab[idx];
    s = p[N] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end
`else
  logic signed [N-1:0] tab [2**(N+1)];
  for (genvar k = 0; k < 2 ** (N + 1); k++) begin : g_tab
    assign tab[k] = N'(sine_entry(k, N));
  end
  assign s = tab[p];
`endif
endmodule

// File: rtl/dds_sine.sv
// dds_sine: phase accumulator + sine lookup + amplitude multiply, one sample per clock
// clock, reset (async, active high); bus: dds_if.slave. Build option: DDS_QUARTER_LUT_EN.
module dds_sine import dds_pkg::*; #(parameter int N = N_DEFAULT) (
  input logic  clock,
  input logic  reset,
  dds_if.slave bus
);
  logic [N:0] acc, amp_r, p;
  logic signed [N-1:0] s, sine_r;
  logic signed [2*N:0] prod;
  assign p = acc + bus.phase_in;
  // Amplitude is zero-extended so the signed multiply treats it as unsigned; the product always fits.
  assign prod = $signed({{N{1'b0}}, amp_r}) * (2*N+1)'(sine_r);
  dds_sine_lut #(.N(N)) u_lut (.p(p), .s(s));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      acc <= '0;
      sine_r <= '0;
      amp_r <= '0;
      bus.out <= '0;
    end else begin
      acc <= acc + bus.freq_in;
      sine_r <= s;
      amp_r <= bus.amplitude_in;
      bus.out <= prod;
    end
endmodule

// File: tb/tb_dds_sine.sv
// tb_dds_sine: directed and random checks of two dds_sine instances against a sample-delay model
module tb_dds_sine;
  localparam int N = 8;
  localparam int M = 512;
  logic clock = 0;
  logic reset = 1;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;
  bit anti = 0;
  int acc_m [2];
  int pend_m [2];
  int exp_m [2];
  int qseq [4];
  dds_if #(N) ifa ();
  dds_if #(N) ifb ();
  dds_sine #(.N(N)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
  dds_sine #(.N(N)) dut_b (.clock(clock), .reset(reset), .bus(ifb));
  always #5 clock = ~clock;

  function automatic int s_ref(int p);
    return int'(127.0 * $sin(6.283185307179586 * real'(p % M) / real'(M)));
  endfunction

  task automatic check(string name, int act, int expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic set_a(int f, int p, int a);
    ifa.freq_in = 9'(f);
    ifa.phase_in = 9'(p);
    ifa.amplitude_in = 9'(a);
  endtask

  task automatic set_b(int f, int p, int a);
    ifb.freq_in = 9'(f);
    ifb.phase_in = 9'(p);
    ifb.amplitude_in = 9'(a);
  endtask

  task automatic rst_with(int f, int p, int a);
    @(negedge clock);
    reset = 1;
    set_a(f, p, a);
    #1 check("rst_out", int'(ifa.out), 0);
    @(negedge clock);
    reset = 0;
  endtask

  // Sample taken from the phase and amplitude present at an edge reaches out one edge later.
  always @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        acc_m[i] <= 0;
        pend_m[i] <= 0;
        exp_m[i] <= 0;
      end
    end else begin
      exp_m[0] <= pend_m[0];
      pend_m[0] <= int'(ifa.amplitude_in) * s_ref(acc_m[0] + int'(ifa.phase_in));
      acc_m[0] <= (acc_m[0] + int'(ifa.freq_in)) % M;
      exp_m[1] <= pend_m[1];
      pend_m[1] <= int'(ifb.amplitude_in) * s_ref(acc_m[1] + int'(ifb.phase_in));
      acc_m[1] <= (acc_m[1] + int'(ifb.freq_in)) % M;
    end

  always @(negedge clock)
    if (chk_en) begin
      check("out_a", int'(ifa.out), exp_m[0]);
      check("out_b", int'(ifb.out), exp_m[1]);
      if (anti) check("anti_phase", int'(ifb.out), -255 * int'(ifa.out));
    end

  initial begin
    qseq = '{0, 127, 0, -127};
    set_a(5, 0, 300);
    set_b(7, 100, 400);
    repeat (2) @(negedge clock);
    reset = 0;
    chk_en = 1;
    repeat (40) @(negedge clock);
    @(posedge clock);
    #3 reset = 1;
    #1 check("async_rst_out_a", int'(ifa.out), 0);
    check("async_rst_out_b", int'(ifb.out), 0);
    check("async_rst_acc", int'(dut_a.acc), 0);
    @(negedge clock);
    set_a(1, 0, 1);
    set_b(1, 256, 255);
    anti = 1;
    reset = 0;
    repeat (3) @(posedge clock);
    #1 check("ramp_s1", int'(ifa.out), 2);
    repeat (127) @(posedge clock);
    #1 check("peak_a", int'(ifa.out), 127);
    check("peak_b", int'(ifb.out), -32385);
    repeat (256) @(posedge clock);
    #1 check("trough_a", int'(ifa.out), -127);
    check("trough_b", int'(ifb.out), 32385);
    repeat (256) @(posedge clock);
    #1 check("period_a", int'(ifa.out), 127);
    anti = 0;
    rst_with(128, 0, 1);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clock);
      #1 check("quarter", int'(ifa.out), e >= 2 ? qseq[(e - 2) % 4] : 0);
    end
    rst_with(0, 64, 2);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clock);
      #1 check("freeze", int'(ifa.out), e >= 2 ? 180 : 0);
    end
    rst_with(0, 0, 511);
    repeat (4) @(posedge clock);
    @(negedge clock);
    ifa.phase_in = 9'd128;
    @(posedge clock);
    #1 check("latency_1", int'(ifa.out), 0);
    @(posedge clock);
    #1 check("latency_2", int'(ifa.out), 64897);
    rst_with(256, 0, 3);
    repeat (20) @(negedge clock);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      set_a(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
      set_b(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
    end
    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
